multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the datapath strobes (PCWr, RegWr, DmWr, ALUSrc, RegDst, PCSrc, ALUOp) over several cycles instead of asserting them all at once per instruction.
- Waits on a memory-ready handshake; counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  instruction register contents; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- zero  in  1  ALU zero flag (for beq).
- IrWr  out  1  load instruction register.
- PCWr  out  1  write PC.
- PCSrc  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = Rs (jr).
- MemRd  out  1  memory read strobe.
- DmWr  out  1  data memory write strobe.
- MemOut  out  1  register write data from memory (1) or ALU (0).
- ALUSrc  out  1  ALU operand B: 0 = Rt, 1 = sign-extended Imm16.
- ALUOp  out  3  0 = ADD, 1 = SUB, 2 = SLT.
- RegDst  out  2  destination register: 0 = Rd, 1 = Rt, 2 = r31.
- RegWr  out  1  register file write.
- state  out  3  current FSM state, for debug.
- retired  out  CNT_W  instructions completed.
- illegal  out  1  sticky: unsupported opcode/funct decoded.

Behaviour:
- Reset is asynchronous:
  - state = FETCH, retired = 0, illegal = 0.
  - All strobes are 0 while rst is high.
  - Reset mid-instruction aborts it with no partial PC/Reg/Dm write.
- Strobes are combinational from registered state plus instr fields.
- Defaults in every state: all strobes 0, ALUOp = ADD, PCSrc = 0, RegDst = 0.
- Supported instructions:
  - R-type (op 000000): funct 100000 add, 100010 sub, 101010 slt, 001000 jr.
  - I/J-type: addi 001000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH:
  - MemRd = 1.
  - If mem_ready: IrWr = 1, PCWr = 1, PCSrc = 0, next state DECODE. Otherwise stay.
- DECODE: one cycle, no strobes. Next state:
  - R arithmetic, addi, lw, sw -> EXEC.
  - beq -> BRANCH.
  - j, jal, jr -> JUMP.
  - Anything else -> TRAP.
- EXEC:
  - R-type: ALUOp from funct, ALUSrc = 0.
  - addi/lw/sw: ALUOp = ADD, ALUSrc = 1.
  - Next state: lw/sw -> MEM, else WB.
- MEM:
  - lw: MemRd = 1, ALUSrc = 1. When mem_ready -> WB.
  - sw: DmWr = 1, ALUSrc = 1. When mem_ready -> FETCH and retire.
  - DmWr stays high until mem_ready; exactly one write is accepted.
- WB:
  - RegWr = 1.
  - R-type: RegDst = 0, MemOut = 0.
  - addi: RegDst = 1, MemOut = 0.
  - lw: RegDst = 1, MemOut = 1.
  - Next state FETCH; retire.
- BRANCH:
  - ALUOp = SUB, ALUSrc = 0, PCSrc = 1, PCWr = zero.
  - Next state FETCH; retire.
- JUMP:
  - PCWr = 1; PCSrc = 2 for j/jal, 3 for jr.
  - jal also asserts RegWr = 1, RegDst = 2.
  - Next state FETCH; retire.
- TRAP:
  - illegal set to 1; stays in TRAP with all strobes 0 until rst.
  - retired does not increment.
- retire: retired += 1 on the clock edge leaving the final state. Wraps from 2^CNT_W - 1 to 0.
- mem_ready is ignored outside FETCH/MEM; a mem_ready held high stays harmless.
- Latency with mem_ready = 1 (cycles):
  - R/addi 4, lw 5, sw 4, beq 3, j/jal/jr 3.
  - Each cycle mem_ready is low adds one cycle in FETCH/MEM.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, BRANCH 5, JUMP 6, TRAP 7.

Decomposition:
- Shared package mips_defs:
  - Opcode and funct constants.
  - ALUOp codes (ADD/SUB/SLT).
  - PCSrc and RegDst encodings.
  - State encoding.
- One natural sub-module, ctrl_decode (combinational):
  - Maps opcode/funct to an instruction class (RTYPE, ADDI, LW, SW, BEQ, J, JAL, JR, ILLEGAL) and an R-type ALUOp.
  - The FSM consumes only the class.

Test Plan:
- add: instr = 0x03E08820, mem_ready = 1 -> states 0,1,2,4,0. RegWr = 1 only in WB with RegDst = 0, ALUOp = 0. retired 0 -> 1.
- addi then lw:
  - addi 0x2008_0005 -> EXEC: ALUSrc = 1; WB: RegDst = 1.
  - lw 0x8D09_0004 with mem_ready low 2 cycles in MEM -> MemRd held 3 cycles, MemOut = 1 in WB. Total 7 cycles.
- sw 0xAD09_0000 -> DmWr high in MEM only until mem_ready, then FETCH. RegWr never asserted.
- beq 0x1109_0003:
  - zero = 1 -> PCWr = 1, PCSrc = 1 in BRANCH.
  - zero = 0 -> PCWr = 0.
  - Both cases retire in 3 cycles.
- jal 0x0C00_0010 -> JUMP: PCWr = 1, PCSrc = 2, RegWr = 1, RegDst = 2. jr 0x03E0_0008 -> PCSrc = 3, RegWr = 0.
- Illegal op 0x3C00_0000 -> TRAP, illegal = 1, held 10 cycles. Assert rst mid-EXEC of a following add -> state 0, retired 0, illegal 0, no RegWr pulse.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared MIPS control definitions: opcodes, functs, ALU/PC/RegDst codes, FSM states, instruction classes.
// Pure declarations, no logic.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] RD_RD    = 2'd0;
    localparam logic [1:0] RD_RT    = 2'd1;
    localparam logic [1:0] RD_R31   = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_JUMP   = 3'd6,
        ST_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        IC_RTYPE, IC_ADDI, IC_LW, IC_SW, IC_BEQ, IC_J, IC_JAL, IC_JR, IC_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode/funct classifier; also yields the ALU op for R-type arithmetic.
// Zero latency, no flow control.
module ctrl_decode
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_e    iclass,
    output logic [2:0] r_aluop
);

    always_comb begin
        iclass  = IC_ILLEGAL;
        r_aluop = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  iclass = IC_RTYPE;
                    FN_SUB:  begin iclass = IC_RTYPE; r_aluop = ALU_SUB; end
                    FN_SLT:  begin iclass = IC_RTYPE; r_aluop = ALU_SLT; end
                    FN_JR:   iclass = IC_JR;
                    default: iclass = IC_ILLEGAL;
                endcase
            end
            OP_ADDI: iclass = IC_ADDI;
            OP_LW:   iclass = IC_LW;
            OP_SW:   iclass = IC_SW;
            OP_BEQ:  iclass = IC_BEQ;
            OP_J:    iclass = IC_J;
            OP_JAL:  iclass = IC_JAL;
            default: iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction plus one per cycle mem_ready is low
// in FETCH/MEM; strobes are decoded from registered state and forced low while rst is high.
module multicycle_control
    import mips_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             IrWr,
    output logic             PCWr,
    output logic [1:0]       PCSrc,
    output logic             MemRd,
    output logic             DmWr,
    output logic             MemOut,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic [1:0]       RegDst,
    output logic             RegWr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    iclass_e          iclass;
    logic [2:0]       r_aluop;
    logic             retire;
    logic             unused_instr;

    assign unused_instr = ^instr[25:6];

    ctrl_decode u_decode (
        .opcode  (instr[31:26]),
        .funct   (instr[5:0]),
        .iclass  (iclass),
        .r_aluop (r_aluop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (iclass)
                    IC_RTYPE, IC_ADDI, IC_LW, IC_SW: state_d = ST_EXEC;
                    IC_BEQ:                          state_d = ST_BRANCH;
                    IC_J, IC_JAL, IC_JR:             state_d = ST_JUMP;
                    default:                         state_d = ST_TRAP;
                endcase
            end
            ST_EXEC:   state_d = (iclass == IC_LW || iclass == IC_SW) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (mem_ready) begin
                    // A store completes here; a load still needs its writeback.
                    state_d = (iclass == IC_SW) ? ST_FETCH : ST_WB;
                    retire  = (iclass == IC_SW);
                end
            end
            ST_WB, ST_BRANCH, ST_JUMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default:   state_d = ST_TRAP;
        endcase
        retired_d = retired_q + CNT_W'(retire);
        illegal_d = illegal_q | (state_d == ST_TRAP);
    end

    always_comb begin
        IrWr   = 1'b0;
        PCWr   = 1'b0;
        PCSrc  = PC_SEQ;
        MemRd  = 1'b0;
        DmWr   = 1'b0;
        MemOut = 1'b0;
        ALUSrc = 1'b0;
        ALUOp  = ALU_ADD;
        RegDst = RD_RD;
        RegWr  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    MemRd = 1'b1;
                    if (mem_ready) begin
                        IrWr = 1'b1;
                        PCWr = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (iclass == IC_RTYPE) ALUOp  = r_aluop;
                    else                    ALUSrc = 1'b1;
                end
                ST_MEM: begin
                    ALUSrc = 1'b1;
                    if (iclass == IC_SW) DmWr  = 1'b1;
                    else                 MemRd = 1'b1;
                end
                ST_WB: begin
                    RegWr = 1'b1;
                    if (iclass == IC_ADDI || iclass == IC_LW) RegDst = RD_RT;
                    if (iclass == IC_LW)                      MemOut = 1'b1;
                end
                ST_BRANCH: begin
                    ALUOp = ALU_SUB;
                    PCSrc = PC_BRANCH;
                    PCWr  = zero;
                end
                ST_JUMP: begin
                    PCWr  = 1'b1;
                    PCSrc = (iclass == IC_JR) ? PC_RS : PC_JUMP;
                    if (iclass == IC_JAL) begin
                        RegWr  = 1'b1;
                        RegDst = RD_R31;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus pushes per-cycle expectations into a queue,
// an independent negedge monitor pops and compares them.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instr;
    logic          mem_ready;
    logic          zero;
    logic          IrWr, PCWr, MemRd, DmWr, MemOut, ALUSrc, RegWr, illegal;
    logic [1:0]    PCSrc, RegDst;
    logic [2:0]    ALUOp, state;
    logic [CW-1:0] retired;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .IrWr(IrWr), .PCWr(PCWr), .PCSrc(PCSrc), .MemRd(MemRd), .DmWr(DmWr),
        .MemOut(MemOut), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegDst(RegDst),
        .RegWr(RegWr), .state(state), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [2:0]    st;
        logic [13:0]   sb;
        logic [CW-1:0] ret;
        logic          ill;
    } exp_t;

    exp_t          exp_q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    int            step   = 0;
    logic [CW-1:0] r      = '0;
    logic          il     = 1'b0;

    // Strobe bundle order: IrWr PCWr PCSrc MemRd DmWr MemOut ALUSrc ALUOp RegDst RegWr
    function automatic logic [13:0] sb(input logic irwr, input logic pcwr, input logic [1:0] pcsrc,
                                       input logic memrd, input logic dmwr, input logic memout,
                                       input logic alusrc, input logic [2:0] aluop,
                                       input logic [1:0] regdst, input logic regwr);
        return {irwr, pcwr, pcsrc, memrd, dmwr, memout, alusrc, aluop, regdst, regwr};
    endfunction

    logic [13:0] S_NONE, S_FET, S_FWAIT;
    assign S_NONE  = 14'd0;
    assign S_FET   = sb(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    assign S_FWAIT = sb(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    always @(negedge clk) begin
        exp_t        e;
        logic [13:0] act;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {IrWr, PCWr, PCSrc, MemRd, DmWr, MemOut, ALUSrc, ALUOp, RegDst, RegWr};
            n_chk++;
            if (state !== e.st || act !== e.sb || retired !== e.ret || illegal !== e.ill) begin
                n_fail++;
                $display("FAIL step%0d: got state=%0d strobes=%h retired=%0d illegal=%b, expected state=%0d strobes=%h retired=%0d illegal=%b",
                         e.id, state, act, retired, illegal, e.st, e.sb, e.ret, e.ill);
            end
        end
    end

    task automatic push(input logic [2:0] st, input logic [13:0] s);
        exp_t x;
        x.id = step; x.st = st; x.sb = s; x.ret = r; x.ill = il;
        exp_q.push_back(x);
        step++;
    endtask

    task automatic cyc(input logic mr, input logic [2:0] st, input logic [13:0] s);
        mem_ready = mr;
        push(st, s);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [31:0] ins, input int waits);
        instr = ins;
        repeat (waits) cyc(0, 3'd0, S_FWAIT);
        cyc(1, 3'd0, S_FET);
        cyc(1, 3'd1, S_NONE);
    endtask

    task automatic retire_one();
        r = r + 1'b1;
    endtask

    task automatic run_rtype(input logic [31:0] ins, input logic [2:0] aluop);
        fetch_decode(ins, 0);
        cyc(1, 3'd2, sb(0, 0, 0, 0, 0, 0, 0, aluop, 0, 0));
        cyc(1, 3'd4, sb(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        retire_one();
    endtask

    task automatic run_jump(input logic [31:0] ins, input logic [1:0] pcsrc, input logic link);
        fetch_decode(ins, 0);
        cyc(1, 3'd6, sb(0, 1, pcsrc, 0, 0, 0, 0, 0, link ? 2'd2 : 2'd0, link));
        retire_one();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; instr = 32'h0; mem_ready = 1'b1; zero = 1'b0;
        @(posedge clk);
        #1;
        // Reset with mem_ready high: FETCH strobes must stay gated.
        cyc(1, 3'd0, S_NONE);
        cyc(1, 3'd0, S_NONE);
        rst = 1'b0;

        run_rtype(32'h03E08820, 3'd0);           // add

        fetch_decode(32'h20080005, 0);           // addi
        cyc(1, 3'd2, sb(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc(1, 3'd4, sb(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        retire_one();

        fetch_decode(32'h8D090004, 0);           // lw, memory stalls twice
        cyc(1, 3'd2, sb(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc(0, 3'd3, sb(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        cyc(0, 3'd3, sb(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        cyc(1, 3'd3, sb(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        cyc(1, 3'd4, sb(0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        retire_one();

        fetch_decode(32'hAD090000, 2);           // sw, fetch stalls twice
        cyc(1, 3'd2, sb(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc(0, 3'd3, sb(0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        cyc(1, 3'd3, sb(0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        retire_one();

        zero = 1'b1;                             // beq taken
        fetch_decode(32'h11090003, 0);
        cyc(1, 3'd5, sb(0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        retire_one();
        zero = 1'b0;                             // beq not taken
        fetch_decode(32'h11090003, 0);
        cyc(1, 3'd5, sb(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        retire_one();

        run_jump(32'h0C000010, 2'd2, 1'b1);      // jal
        run_jump(32'h03E00008, 2'd3, 1'b0);      // jr
        run_rtype(32'h02328822, 3'd1);           // sub
        run_rtype(32'h0232882A, 3'd2);           // slt

        // Seven j's take retired from 10 through 15 and wrap to 1.
        for (int k = 0; k < 7; k++) run_jump(32'h08000010, 2'd2, 1'b0);

        fetch_decode(32'h3C000000, 0);           // lui: unsupported
        il = 1'b1;
        repeat (10) cyc(1, 3'd7, S_NONE);

        rst = 1'b1;
        r = '0; il = 1'b0;
        cyc(1, 3'd0, S_NONE);
        rst = 1'b0;

        // add aborted by reset in the middle of EXEC: no WB write may follow.
        fetch_decode(32'h03E08820, 0);
        mem_ready = 1'b1;
        push(3'd2, S_NONE);
        #5;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 3'd0, S_NONE);
        cyc(1, 3'd0, S_NONE);
        rst = 1'b0;
        cyc(1, 3'd0, S_FET);
        cyc(1, 3'd1, S_NONE);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
